// File: rtl/if_id_buf_pkg.sv
// Shared constants and types for the IF/ID buffer slice.
// These values stand in for the processor-wide defines (InstAddrBus, InstBus, ZeroWord, RstEnable, NOP_INST, ChipEnable).
package if_id_buf_pkg;

    localparam int          INST_ADDR_BUS = 32;
    localparam int          INST_BUS      = 32;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [31:0] NOP_INST      = 32'h0000_0000;
    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic        CHIP_ENABLE   = 1'b1;
    localparam logic        CHIP_DISABLE  = 1'b0;

    // Source of the next IF/ID register contents.
    typedef enum logic [1:0] {
        ID_LOAD_HOLD,
        ID_LOAD_HEAD,
        ID_LOAD_BYPASS,
        ID_LOAD_EMPTY
    } id_load_e;

endpackage

// File: rtl/if_id_buf_fifo.sv
// In-order ring buffer holding fetched {pc, inst} entries between fetch and the IF/ID register.
// Pointers wrap naturally because DEPTH is a power of two.
module if_fifo
    import if_id_buf_pkg::*;
#(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rdPtr_q];

    assign doPush = push_i && !full_o && !clear_i;
    assign doPop  = pop_i && !empty_o && !clear_i;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (clear_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (doPush && (rst != RST_ENABLE)) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/if_id_buf.sv
// Fetch-to-decode buffer: queues fetched {pc, inst} pairs and presents them in a registered IF/ID stage.
// Define IF_ID_PERF_EN to add the perf_stall_cnt / perf_bubble_cnt counters.
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = INST_ADDR_BUS,
    parameter int INST_W = INST_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic              stall_id,
    input  logic              flush,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_valid
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    localparam int ENTRY_W = ADDR_W + INST_W;

    logic               push;
    logic               fifoPush;
    logic               fifoPop;
    logic               fifoClear;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [ENTRY_W-1:0] fifoHead;
    logic               advanceBubble;
    id_load_e           loadSel;

    logic [ADDR_W-1:0]  idPc_q, idPc_d;
    logic [INST_W-1:0]  idInst_q, idInst_d;
    logic               idValid_q, idValid_d;

    // Ready depends only on registered occupancy, so stall/flush never reach fetch combinationally.
    assign if_ready = (rst != RST_ENABLE) && !fifoFull;
    assign push     = if_valid && if_ready;

    if_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .clear_i (fifoClear),
        .wdata_i ({if_pc, if_inst}),
        .rdata_o (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Flush beats stall; with nothing queued a fresh fetch bypasses straight into the output stage.
    always_comb begin
        loadSel       = ID_LOAD_HOLD;
        fifoPush      = 1'b0;
        fifoPop       = 1'b0;
        fifoClear     = 1'b0;
        advanceBubble = 1'b0;
        if (flush) begin
            fifoClear = 1'b1;
            loadSel   = ID_LOAD_EMPTY;
        end else if (stall_id) begin
            fifoPush = push;
        end else if (!fifoEmpty) begin
            loadSel  = ID_LOAD_HEAD;
            fifoPop  = 1'b1;
            fifoPush = push;
        end else if (push) begin
            loadSel = ID_LOAD_BYPASS;
        end else begin
            loadSel       = ID_LOAD_EMPTY;
            advanceBubble = 1'b1;
        end
    end

    always_comb begin
        idPc_d    = idPc_q;
        idInst_d  = idInst_q;
        idValid_d = idValid_q;
        unique case (loadSel)
            ID_LOAD_HOLD: begin
                idPc_d    = idPc_q;
                idInst_d  = idInst_q;
                idValid_d = idValid_q;
            end
            ID_LOAD_HEAD: begin
                {idPc_d, idInst_d} = fifoHead;
                idValid_d          = 1'b1;
            end
            ID_LOAD_BYPASS: begin
                idPc_d    = if_pc;
                idInst_d  = if_inst;
                idValid_d = 1'b1;
            end
            default: begin
                idPc_d    = ADDR_W'(ZERO_WORD);
                idInst_d  = INST_W'(NOP_INST);
                idValid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            idPc_q    <= ADDR_W'(ZERO_WORD);
            idInst_q  <= INST_W'(NOP_INST);
            idValid_q <= 1'b0;
        end else begin
            idPc_q    <= idPc_d;
            idInst_q  <= idInst_d;
            idValid_q <= idValid_d;
        end
    end

    assign id_pc    = idPc_q;
    assign id_inst  = idInst_q;
    assign id_valid = idValid_q;

`ifdef IF_ID_PERF_EN
    logic [31:0] perfStall_q, perfStall_d;
    logic [31:0] perfBubble_q, perfBubble_d;

    // Counters survive flush; only reset clears them, and they wrap silently.
    always_comb begin
        perfStall_d  = perfStall_q;
        perfBubble_d = perfBubble_q;
        if (stall_id && idValid_q) begin
            perfStall_d = perfStall_q + 32'd1;
        end
        if (advanceBubble) begin
            perfBubble_d = perfBubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            perfStall_q  <= '0;
            perfBubble_q <= '0;
        end else begin
            perfStall_q  <= perfStall_d;
            perfBubble_q <= perfBubble_d;
        end
    end

    assign perf_stall_cnt  = perfStall_q;
    assign perf_bubble_cnt = perfBubble_q;
`endif

endmodule
